noc_vc_input_buffer: RTL and testbench

//  Router input-port buffer with one FIFO per virtual channel, generalised in VC count and depth.

---
 rtl/noc_vc_input_buffer_if.sv | 39 +++
 rtl/noc_vc_input_buffer.sv | 163 ++++++++++++++++
 tb/tb_noc_vc_input_buffer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/noc_vc_input_buffer_if.sv
// Link/switch-side bundle of the per-port virtual-channel input buffer.
//  slave : the buffer (takes flits and pops, returns heads, credits, status)
//  master: the upstream link plus switch allocator (drives flits and pops)
//  in_valid/in_vc/in_flit  flit from the upstream link, tagged with its VC
//  out_valid/out_flit/out_head  per-VC head flit presented to the allocator
//  out_pop                 per-VC dequeue request
//  credit_out              per-VC one-cycle credit pulse back to upstream
//  vc_busy                 per-VC "inside a packet" status
//  err_overflow/err_framing sticky error flags
interface noc_vc_input_buffer_if #(
  parameter int unsigned FLIT_W = 64,
  parameter int unsigned NUM_VC = 4
);
  localparam int unsigned VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  logic                     in_valid;
  logic [VCW-1:0]           in_vc;
  logic [FLIT_W-1:0]        in_flit;
  logic [NUM_VC-1:0]        out_valid;
  logic [NUM_VC*FLIT_W-1:0] out_flit;
  logic [NUM_VC-1:0]        out_head;
  logic [NUM_VC-1:0]        out_pop;
  logic [NUM_VC-1:0]        credit_out;
  logic [NUM_VC-1:0]        vc_busy;
  logic                     err_overflow;
  logic                     err_framing;

  modport slave (
    input  in_valid, in_vc, in_flit, out_pop,
    output out_valid, out_flit, out_head, credit_out, vc_busy,
           err_overflow, err_framing
  );

  modport master (
    output in_valid, in_vc, in_flit, out_pop,
    input  out_valid, out_flit, out_head, credit_out, vc_busy,
           err_overflow, err_framing
  );
endinterface

// File: rtl/noc_vc_input_buffer.sv
// Router input-port buffer: one circular FIFO per virtual channel, credit
// return per dequeued flit, and per-VC head/tail packet framing tracking.
//  clk  rising-edge clock
//  rst  synchronous active-high reset
//  bus  noc_vc_input_buffer_if.slave (link input, per-VC heads, pops,
//       credits, busy status, sticky error flags)
module noc_vc_input_buffer #(
  parameter int unsigned FLIT_W = 64,
  parameter int unsigned NUM_VC = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  noc_vc_input_buffer_if.slave   bus
);
  localparam int unsigned VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} frame_state_e;

  logic [FLIT_W-1:0] mem_q [NUM_VC][DEPTH];
  logic [FLIT_W-1:0] mem_d [NUM_VC][DEPTH];
  logic [PW-1:0]     rd_ptr_q [NUM_VC];
  logic [PW-1:0]     rd_ptr_d [NUM_VC];
  logic [PW-1:0]     wr_ptr_q [NUM_VC];
  logic [PW-1:0]     wr_ptr_d [NUM_VC];
  logic [CW-1:0]     cnt_q    [NUM_VC];
  logic [CW-1:0]     cnt_d    [NUM_VC];
  frame_state_e      state_q  [NUM_VC];
  frame_state_e      state_d  [NUM_VC];
  logic [NUM_VC-1:0] credit_q, credit_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_frm_q, err_frm_d;

  logic              vc_ok_c;
  logic [VCW-1:0]    wvc_c;
  logic [1:0]        in_type_c;
  logic [NUM_VC-1:0] pop_ok_c;
  logic              push_ok_c;
  logic              overflow_c;
  logic              frm_err_c;

  // Request decode: legal VC, accepted pops, accepted push (a same-cycle pop frees a full VC)
  always_comb begin
    vc_ok_c    = 32'(bus.in_vc) < NUM_VC;
    wvc_c      = vc_ok_c ? bus.in_vc : '0;
    in_type_c  = bus.in_flit[FLIT_W-1 -: 2];
    pop_ok_c   = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      pop_ok_c[v] = bus.out_pop[v] & (cnt_q[v] != '0);
    end
    push_ok_c  = bus.in_valid & vc_ok_c &
                 ((cnt_q[wvc_c] != CW'(DEPTH)) | pop_ok_c[wvc_c]);
    overflow_c = bus.in_valid & vc_ok_c & ~push_ok_c;
  end

  // FIFO pointers, counts, storage, credits and sticky errors
  always_comb begin
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    credit_d  = pop_ok_c;
    err_ovf_d = err_ovf_q | overflow_c;
    err_frm_d = err_frm_q | (bus.in_valid & ~vc_ok_c) | (push_ok_c & frm_err_c);
    if (push_ok_c) begin
      mem_d[wvc_c][wr_ptr_q[wvc_c]] = bus.in_flit;
    end
    for (int v = 0; v < NUM_VC; v++) begin
      logic push_here;
      push_here = push_ok_c & (wvc_c == VCW'(v));
      if (pop_ok_c[v]) rd_ptr_d[v] = rd_ptr_q[v] + PW'(1);
      if (push_here)   wr_ptr_d[v] = wr_ptr_q[v] + PW'(1);
      cnt_d[v] = cnt_q[v] + CW'(push_here) - CW'(pop_ok_c[v]);
    end
  end

  // Framing next state: state always follows the accepted flit's type; an
  // unexpected type/state pair only raises the error
  always_comb begin
    state_d   = state_q;
    frm_err_c = 1'b0;
    if (push_ok_c) begin
      unique case (in_type_c)
        FT_HEAD: begin
          frm_err_c      = (state_q[wvc_c] == ST_ACTIVE);
          state_d[wvc_c] = ST_ACTIVE;
        end
        FT_BODY: begin
          frm_err_c      = (state_q[wvc_c] == ST_IDLE);
        end
        FT_TAIL: begin
          frm_err_c      = (state_q[wvc_c] == ST_IDLE);
          state_d[wvc_c] = ST_IDLE;
        end
        FT_SINGLE: begin
          frm_err_c      = (state_q[wvc_c] == ST_ACTIVE);
          state_d[wvc_c] = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Framing state register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) state_q[v] <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control/status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        rd_ptr_q[v] <= '0;
        wr_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
      credit_q  <= '0;
      err_ovf_q <= 1'b0;
      err_frm_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      credit_q  <= credit_d;
      err_ovf_q <= err_ovf_d;
      err_frm_q <= err_frm_d;
    end
  end

  // Flit storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Outputs: head flit fall-through from storage; HEAD (01) and SINGLE (11)
  // share a set low type bit, so that bit alone marks a packet start
  always_comb begin
    bus.out_valid    = '0;
    bus.out_flit     = '0;
    bus.out_head     = '0;
    bus.vc_busy      = '0;
    bus.credit_out   = credit_q;
    bus.err_overflow = err_ovf_q;
    bus.err_framing  = err_frm_q;
    for (int v = 0; v < NUM_VC; v++) begin
      bus.out_valid[v]                = (cnt_q[v] != '0);
      bus.out_flit[v*FLIT_W +: FLIT_W] = mem_q[v][rd_ptr_q[v]];
      bus.out_head[v]                 = (cnt_q[v] != '0) & mem_q[v][rd_ptr_q[v]][FLIT_W-2];
      bus.vc_busy[v]                  = (state_q[v] == ST_ACTIVE);
    end
  end
endmodule

// File: tb/tb_noc_vc_input_buffer.sv
module tb_noc_vc_input_buffer;
  localparam int unsigned FLIT_W = 64;
  localparam int unsigned NUM_VC = 4;
  localparam int unsigned DEPTH  = 4;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  noc_vc_input_buffer_if #(.FLIT_W(FLIT_W), .NUM_VC(NUM_VC)) bus ();

  noc_vc_input_buffer #(.FLIT_W(FLIT_W), .NUM_VC(NUM_VC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per VC plus packet-open flag and sticky errors
  logic [FLIT_W-1:0] mq [NUM_VC][$];
  bit                m_open [NUM_VC];
  logic [NUM_VC-1:0] m_credit;
  logic              m_ovf;
  logic              m_frm;

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [61:0] payload);
    return {t, payload};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic v, input int vc, input logic [FLIT_W-1:0] f,
                            input logic [NUM_VC-1:0] pop, input logic r);
    logic [NUM_VC-1:0] taken;
    logic [1:0]        t;
    if (r) begin
      for (int i = 0; i < NUM_VC; i++) begin
        mq[i].delete();
        m_open[i] = 1'b0;
      end
      m_credit = '0;
      m_ovf    = 1'b0;
      m_frm    = 1'b0;
      return;
    end
    for (int i = 0; i < NUM_VC; i++) taken[i] = pop[i] && (mq[i].size() > 0);
    if (v) begin
      if (mq[vc].size() == DEPTH && !taken[vc]) begin
        m_ovf = 1'b1;
      end else begin
        t = f[FLIT_W-1 -: 2];
        if (!m_open[vc] && (t == T_BODY || t == T_TAIL)) m_frm = 1'b1;
        if ( m_open[vc] && (t == T_HEAD || t == T_SINGLE)) m_frm = 1'b1;
        if (t == T_HEAD) m_open[vc] = 1'b1;
        else if (t != T_BODY) m_open[vc] = 1'b0;
        mq[vc].push_back(f);
      end
    end
    for (int i = 0; i < NUM_VC; i++) if (taken[i]) void'(mq[i].pop_front());
    m_credit = taken;
  endtask

  task automatic check_all();
    logic [1:0] t;
    for (int i = 0; i < NUM_VC; i++) begin
      chk($sformatf("out_valid[%0d]", i), 64'(bus.out_valid[i]), 64'(mq[i].size() != 0));
      chk($sformatf("vc_busy[%0d]", i), 64'(bus.vc_busy[i]), 64'(m_open[i]));
      if (mq[i].size() != 0) begin
        t = mq[i][0][FLIT_W-1 -: 2];
        chk($sformatf("out_flit[%0d]", i), bus.out_flit[i*FLIT_W +: FLIT_W], mq[i][0]);
        chk($sformatf("out_head[%0d]", i), 64'(bus.out_head[i]),
            64'(t == T_HEAD || t == T_SINGLE));
      end else begin
        chk($sformatf("out_head[%0d]", i), 64'(bus.out_head[i]), 64'(0));
      end
    end
    chk("credit_out", 64'(bus.credit_out), 64'(m_credit));
    chk("err_overflow", 64'(bus.err_overflow), 64'(m_ovf));
    chk("err_framing", 64'(bus.err_framing), 64'(m_frm));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare
  task automatic step(input logic v, input int vc, input logic [FLIT_W-1:0] f,
                      input logic [NUM_VC-1:0] pop, input logic r);
    bus.in_valid = v;
    bus.in_vc    = 2'(vc);
    bus.in_flit  = f;
    bus.out_pop  = pop;
    rst          = r;
    @(posedge clk);
    model_step(v, vc, f, pop, r);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [1:0]  t;
    int          vc;
    int          pop_pct;
    logic [NUM_VC-1:0] pop;
    bus.in_valid = 1'b0;
    bus.in_vc    = '0;
    bus.in_flit  = '0;
    bus.out_pop  = '0;
    rst          = 1'b1;
    for (int i = 0; i < NUM_VC; i++) m_open[i] = 1'b0;
    m_credit = '0;
    m_ovf    = 1'b0;
    m_frm    = 1'b0;

    // Reset, then quiet link
    step(1'b0, 0, '0, '0, 1'b1);
    step(1'b0, 0, '0, '0, 1'b1);
    repeat (10) idle();

    // HEAD/BODY/TAIL on VC2, then drain with one pop per cycle
    step(1'b1, 2, mk(T_HEAD, 62'h21), '0, 1'b0);
    chk("vc2_valid_after_head", 64'(bus.out_valid[2]), 64'(1));
    chk("vc2_busy_after_head", 64'(bus.vc_busy[2]), 64'(1));
    step(1'b1, 2, mk(T_BODY, 62'h22), '0, 1'b0);
    step(1'b1, 2, mk(T_TAIL, 62'h23), '0, 1'b0);
    chk("vc2_idle_after_tail", 64'(bus.vc_busy[2]), 64'(0));
    repeat (3) begin
      step(1'b0, 0, '0, 4'b0100, 1'b0);
      chk("vc2_credit_pulse", 64'(bus.credit_out), 64'(4'b0100));
    end
    idle();
    chk("vc2_credit_clear", 64'(bus.credit_out), 64'(0));

    // Fill VC0, overflow with a fifth flit, drain the original four
    for (int i = 0; i < DEPTH; i++) step(1'b1, 0, mk(T_SINGLE, 62'(256 + i)), '0, 1'b0);
    step(1'b1, 0, mk(T_SINGLE, 62'h1ff), '0, 1'b0);
    chk("vc0_overflow_flag", 64'(bus.err_overflow), 64'(1));
    repeat (DEPTH) step(1'b0, 0, '0, 4'b0001, 1'b0);
    chk("vc0_empty_after_drain", 64'(bus.out_valid[0]), 64'(0));
    step(1'b0, 0, '0, 4'b0001, 1'b0);
    chk("empty_pop_no_credit", 64'(bus.credit_out), 64'(0));

    // Clear errors; VC1 full with simultaneous push and pop
    step(1'b0, 0, '0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1, mk(T_SINGLE, 62'(512 + i)), '0, 1'b0);
    step(1'b1, 1, mk(T_SINGLE, 62'h2ff), 4'b0010, 1'b0);
    chk("vc1_full_pushpop_no_ovf", 64'(bus.err_overflow), 64'(0));
    repeat (DEPTH) step(1'b0, 0, '0, 4'b0010, 1'b0);
    idle();

    // Interleaved packets on VC0 and VC3, popped together
    step(1'b1, 0, mk(T_HEAD, 62'h300), '0, 1'b0);
    step(1'b1, 3, mk(T_HEAD, 62'h330), '0, 1'b0);
    step(1'b1, 0, mk(T_TAIL, 62'h301), '0, 1'b0);
    step(1'b1, 3, mk(T_TAIL, 62'h331), '0, 1'b0);
    step(1'b0, 0, '0, 4'b1001, 1'b0);
    chk("dual_credit", 64'(bus.credit_out), 64'(4'b1001));
    step(1'b0, 0, '0, 4'b1001, 1'b0);
    chk("interleave_no_frm", 64'(bus.err_framing), 64'(0));
    idle();

    // BODY into idle VC1, open a packet on VC2, then reset mid-packet
    step(1'b1, 1, mk(T_BODY, 62'h400), '0, 1'b0);
    chk("body_idle_frm", 64'(bus.err_framing), 64'(1));
    chk("body_idle_stored", 64'(bus.out_valid[1]), 64'(1));
    step(1'b1, 2, mk(T_HEAD, 62'h410), '0, 1'b0);
    step(1'b1, 2, mk(T_BODY, 62'h411), 4'b0110, 1'b1);
    chk("rst_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_busy", 64'(bus.vc_busy), 64'(0));
    chk("rst_credit", 64'(bus.credit_out), 64'(0));

    // Randomised traffic in phases of different drain pressure
    for (int ph = 0; ph < 6; ph++) begin
      pop_pct = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 50 : 90);
      for (int c = 0; c < 120; c++) begin
        t   = 2'($urandom_range(3));
        vc  = int'($urandom_range(NUM_VC - 1));
        pop = '0;
        for (int i = 0; i < NUM_VC; i++) pop[i] = ($urandom_range(99) < pop_pct);
        step(($urandom_range(99) < 60), vc, mk(t, {30'($urandom), $urandom}), pop,
             ($urandom_range(99) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
